// File: rtl/seg_display_capture_if.sv
// Pin-side and report-side signals of the 7-segment capture block.
// master drives the display pins and observes reports; slave is the capture block itself.
interface seg_display_capture_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [19:0] digits;
    logic        frame_valid;
    logic        frame_changed;
    logic        unknown_glyph;
    logic        an_error;
    logic        stale;

    modport master (
        output seg, an,
        input  digits, frame_valid, frame_changed, unknown_glyph, an_error, stale
    );

    modport slave (
        input  seg, an,
        output digits, frame_valid, frame_changed, unknown_glyph, an_error, stale
    );
endinterface

// File: rtl/seg_display_capture.sv
// Samples multiplexed 7-segment pins, decodes each digit and reassembles 4-digit frames.
// Define SEG_CAPTURE_TIMEOUT_EN to build the frame timeout counter and stale flag.
module seg_display_capture #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 262144
) (
    input logic                  clk,
    input logic                  reset,
    seg_display_capture_if.slave bus
);
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] StableLast = CW'(STABLE_CYCLES - 1);

    typedef enum logic {StSettle, StHold} state_e;

    logic [10:0]   sample_q, prev_q;
    logic [CW-1:0] cnt_d, cnt_q;
    state_e        state_d, state_q;
    logic          same, act;
    logic [3:0]    low;
    logic          one_low, multi_low, complete;
    logic [5:0]    dec;
    logic [3:0]    seen_d, seen_q, unk_d, unk_q;
    logic [19:0]   slots_d, slots_q, digits_d, digits_q;
    logic          valid_d, valid_q, changed_d, changed_q;
    logic          glyph_d, glyph_q, an_error_d, an_error_q;

    // Returns {unknown, code}; unlisted patterns read as blank and are flagged.
    function automatic logic [5:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = {1'b0, 5'd0};
            7'b1111001: decode = {1'b0, 5'd1};
            7'b0100100: decode = {1'b0, 5'd2};
            7'b0110000: decode = {1'b0, 5'd3};
            7'b0011001: decode = {1'b0, 5'd4};
            7'b0010010: decode = {1'b0, 5'd5};
            7'b0000010: decode = {1'b0, 5'd6};
            7'b1111000: decode = {1'b0, 5'd7};
            7'b0000000: decode = {1'b0, 5'd8};
            7'b0010000: decode = {1'b0, 5'd9};
            7'b0111111: decode = {1'b0, 5'd10};
            7'b0000110: decode = {1'b0, 5'd11};
            7'b0101111: decode = {1'b0, 5'd12};
            7'b1000111: decode = {1'b0, 5'd13};
            7'b0001001: decode = {1'b0, 5'd14};
            7'b1000001: decode = {1'b0, 5'd15};
            7'b0001100: decode = {1'b0, 5'd16};
            7'b0100011: decode = {1'b0, 5'd17};
            7'b0000011: decode = {1'b0, 5'd18};
            7'b0100001: decode = {1'b0, 5'd19};
            7'b0101011: decode = {1'b0, 5'd20};
            7'b1110001: decode = {1'b0, 5'd21};
            7'b0010001: decode = {1'b0, 5'd22};
            7'b0001011: decode = {1'b0, 5'd30};
            7'b1111111: decode = {1'b0, 5'd31};
            default:    decode = {1'b1, 5'd31};
        endcase
    endfunction

    assign same      = (sample_q == prev_q);
    assign low       = ~sample_q[10:7];
    assign one_low   = $onehot(low);
    assign multi_low = (low != 4'b0000) && !one_low;
    assign dec       = decode(sample_q[6:0]);
    assign complete  = &seen_q;

    always_comb begin
        cnt_d = '0;
        if (same) cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StSettle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSettle: if (cnt_d == StableLast) state_d = StHold;
            StHold:   if (!same) state_d = StSettle;
            default:  state_d = StSettle;
        endcase
    end

    always_comb begin
        act = (state_q == StSettle) && (cnt_d == StableLast);
    end

    // Completion clears seen/unk first so a coincident capture lands in the next frame.
    always_comb begin
        seen_d  = complete ? 4'b0000 : seen_q;
        unk_d   = complete ? 4'b0000 : unk_q;
        slots_d = slots_q;
        if (act && one_low) begin
            for (int i = 0; i < 4; i++) begin
                if (low[i]) begin
                    seen_d[i]         = 1'b1;
                    unk_d[i]          = dec[5];
                    slots_d[5*i +: 5] = dec[4:0];
                end
            end
        end
        digits_d   = complete ? slots_q : digits_q;
        glyph_d    = complete ? |unk_q : glyph_q;
        valid_d    = complete;
        changed_d  = complete && (slots_q != digits_q);
        an_error_d = act && multi_low;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q   <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            seen_q     <= '0;
            unk_q      <= '0;
            slots_q    <= '1;
            digits_q   <= 20'hFFFFF;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            glyph_q    <= 1'b0;
            an_error_q <= 1'b0;
        end else begin
            sample_q   <= {bus.an, bus.seg};
            prev_q     <= sample_q;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            unk_q      <= unk_d;
            slots_q    <= slots_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            glyph_q    <= glyph_d;
            an_error_q <= an_error_d;
        end
    end

`ifdef SEG_CAPTURE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt_d, to_cnt_q;
    logic          stale_d, stale_q;

    always_comb begin
        to_cnt_d = (to_cnt_q == TimeoutVal) ? to_cnt_q : to_cnt_q + 1'b1;
        stale_d  = stale_q || (to_cnt_d == TimeoutVal);
        if (complete) begin
            to_cnt_d = '0;
            stale_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
            stale_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            stale_q  <= stale_d;
        end
    end

    assign bus.stale = stale_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign bus.stale      = 1'b0;
`endif

    assign bus.digits        = digits_q;
    assign bus.frame_valid   = valid_q;
    assign bus.frame_changed = changed_q;
    assign bus.unknown_glyph = glyph_q;
    assign bus.an_error      = an_error_q;
endmodule

// File: doc/seg_display_capture.md
# seg_display_capture

Receive-side counterpart of the 7-segment display controller. The block samples the multiplexed cathode (`seg`) and active-low anode (`an`) lines and inverts the 5-bit character encoding. It reassembles the 4-digit, 20-bit `seg_data` frame and reports each completed frame with change, error and staleness flags. It is used for on-chip readback of the display and as a self-checking monitor in board-level benches.

## Interface
- `STABLE_CYCLES`, 16: consecutive identical samples required before a digit is accepted; legal range 2..65535.
- `TIMEOUT_CYCLES`, 262144: cycles without a completed frame before `stale` asserts.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `seg` in 7: cathodes `{g,f,e,d,c,b,a}`, active low.
- `an` in 4: anodes, active low. `an[3]` is the leftmost digit.
- `digits` out 20: last completed frame. `[19:15]` is `an[3]`, `[14:10]` is `an[2]`, `[9:5]` is `an[1]`, `[4:0]` is `an[0]`.
- `frame_valid` out 1: one-cycle pulse when `digits` updates.
- `frame_changed` out 1: one-cycle pulse, coincident with `frame_valid`, when the new `digits` differs from the previous value.
- `unknown_glyph` out 1: the last completed frame contained at least one undecodable pattern. Updated with `digits`.
- `an_error` out 1: one-cycle pulse on acceptance of a stable sample with more than one anode low.
- `stale` out 1: level; no frame completed within `TIMEOUT_CYCLES`.

## Operation
- **Input register:** one register stage captures `{an,seg}` every cycle; all logic uses the registered sample.
- **Stability counter:**
  - Compares the current sample to the previous sample.
  - Equal: increment, saturating.
  - Different: clear to 0.
  - Width is clog2(`STABLE_CYCLES`+1).
- **Per-sample FSM:**
  - `SETTLE`: counting. When the counter reaches `STABLE_CYCLES`-1, act on the sample and go to `HOLD`.
  - `HOLD`: the sample has been consumed. Return to `SETTLE` on any sample change.
  - Consequence: each stable period is acted on exactly once.
- **Acting on a sample:**
  - `an`=1111: ignored (blanking gap).
  - Exactly one anode low: decode `seg` into that slot and set the slot's `seen` bit. A slot captured again before frame completion is overwritten with the latest value.
  - Two or more anodes low: pulse `an_error`; no slot update.
- **Decode map (code:pattern):**
  - Digits: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
  - Letters and symbols: 10:0111111, 11:0000110, 12:0101111, 13:1000111, 14:0001001, 15:1000001, 16:0001100, 17:0100011, 18:0000011, 19:0100001, 20:0101011, 21:1110001, 22:0010001, 30:0001011, 31:1111111.
  - Any other pattern decodes to 31 and sets that slot's `unk` bit.
  - Codes 23..29 are never produced; the driver renders them as blank.
- **Frame completion:**
  - Triggered when all four `seen` bits are set.
  - Load `digits` from the slots.
  - Load `unknown_glyph` from the OR of the `unk` bits.
  - Pulse `frame_valid`; pulse `frame_changed` if the new value differs from the old.
  - Clear `seen` and `unk`.
- **Timeout:**
  - Counter of cycles since the last `frame_valid`, saturating.
  - `stale` sets when the count reaches `TIMEOUT_CYCLES`.
  - `stale` clears in the same cycle `frame_valid` asserts.

## Timing
- **Reset values:**
  - `digits`=20'hFFFFF (all blank).
  - All flags 0; counters 0; FSM in `SETTLE`.
  - `seen`, `unk` and the sample registers cleared.
- **Reset mid-operation:** discards partially assembled frames and restarts the timeout count.
- **Capture latency:** a pin value held from cycle 0 is acted on at the edge ending cycle `STABLE_CYCLES`. That is 1 cycle of input register plus `STABLE_CYCLES`-1 cycles of comparison.
- **Frame latency:** `digits`, `frame_valid`, `frame_changed` and `unknown_glyph` update one edge after the fourth slot's capture edge.
- **Short holds:** a value held fewer than `STABLE_CYCLES` cycles is never captured (glitch rejection).
- **Same-cycle events:** when frame completion and a new slot capture coincide, the new capture goes into the next frame (`seen` is cleared, then the new bit is set).

## Configuration
- Macro: `SEG_CAPTURE_TIMEOUT_EN`.
- Defined: the timeout counter and `stale` are implemented as above.
- Undefined: no timeout counter; `stale` is tied to 0; `TIMEOUT_CYCLES` is ignored.

## Test plan
Bench settings: `STABLE_CYCLES`=4, `TIMEOUT_CYCLES`=100, driven by the display controller timing.
- **Normal frame:** display codes {1,11,12,31}. Required: `digits`=20'h0AD9F; `frame_valid` and `frame_changed` pulse once; `unknown_glyph`=0.
- **Repeat frame:** same frame displayed again. Required: `frame_valid` pulses, `frame_changed` stays 0.
- **Glitch rejection:** `an`=1110 with `seg`=0000000 held 3 cycles, then `an`=1111. Required: no capture; `seen` unchanged.
- **Unknown glyph and multiple anodes:**
  - `seg`=1010101 on `an[0]`: slot decodes to 31, and `unknown_glyph`=1 at frame completion.
  - `an`=0011 held stable: one `an_error` pulse; no slot update.
- **Timeout:** inputs idle with `an`=1111 after reset. Required: `stale`=1 at cycle 100; it clears on the next `frame_valid`.
- **Reset mid-frame:** assert `reset` after two slots are captured. Required: `digits`=20'hFFFFF; the next frame needs all four slots recaptured.
